// File: rtl/fetch_stage_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, FSM states
// and the per-icode length / regid / constant-word rules.
package fetch_stage_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] STAT_BUBBLE = 3'd0;
    localparam logic [2:0] STAT_AOK    = 3'd1;
    localparam logic [2:0] STAT_HLT    = 3'd2;
    localparam logic [2:0] STAT_ADR    = 3'd3;
    localparam logic [2:0] STAT_INS    = 3'd4;

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_READY,
        ST_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
    } f_fields_t;

    localparam f_fields_t F_BUBBLE = '{
        stat:  STAT_BUBBLE,
        pc:    64'h0,
        icode: INOP,
        ifun:  4'h0,
        rA:    RNONE,
        rB:    RNONE,
        valC:  64'h0,
        valP:  64'h0
    };

    function automatic logic icode_valid(input logic [3:0] icode);
        return (icode <= IPOPQ);
    endfunction

    function automatic logic need_regid(input logic [3:0] icode);
        case (icode)
            IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ,
            IOPQ, IPUSHQ, IPOPQ:               return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic need_valc(input logic [3:0] icode);
        case (icode)
            IIRMOVQ, IRMMOVQ, IMRMOVQ,
            IJXX, ICALL:                       return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // Invalid icodes fall through both rules and therefore decode as 1 byte.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        len = 4'd1;
        if (need_regid(icode)) len = len + 4'd1;
        if (need_valc(icode))  len = len + 4'd8;
        return len;
    endfunction

endpackage

// File: rtl/fetch_stage_align.sv
// Combinational byte extraction and field decode of one instruction taken
// from the 24-byte fetch buffer starting at the PC's byte offset.
module fetch_align
    import fetch_stage_pkg::*;
(
    input  logic [191:0] i_buf,
    input  logic [2:0]   i_off,
    input  logic [63:0]  i_pc,
    output logic [2:0]   o_stat,
    output logic [3:0]   o_icode,
    output logic [3:0]   o_ifun,
    output logic [3:0]   o_rA,
    output logic [3:0]   o_rB,
    output logic [63:0]  o_valC,
    output logic [63:0]  o_valP,
    output logic [3:0]   o_len
);

    logic [79:0] w_win;
    logic        w_valid;
    logic        w_regid;
    logic        w_valc;
    logic [63:0] w_valc_raw;

    // Ten bytes from the offset always fit: offset 7 + 10 bytes = 17 <= 24.
    assign w_win      = i_buf[{i_off, 3'b000} +: 80];

    assign o_icode    = w_win[7:4];
    assign o_ifun     = w_win[3:0];
    assign w_valid    = icode_valid(o_icode);
    assign w_regid    = need_regid(o_icode);
    assign w_valc     = need_valc(o_icode);

    assign w_valc_raw = w_regid ? w_win[79:16] : w_win[71:8];

    assign o_rA       = w_regid ? w_win[15:12] : RNONE;
    assign o_rB       = w_regid ? w_win[11:8]  : RNONE;
    assign o_valC     = w_valc ? w_valc_raw : 64'h0;
    assign o_len      = instr_len(o_icode);
    assign o_valP     = i_pc + {60'h0, o_len};

    always_comb begin
        o_stat = STAT_AOK;
        if (!w_valid) begin
            o_stat = STAT_INS;
        end else if (o_icode == IHALT) begin
            o_stat = STAT_HLT;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC selection, multi-word instruction fetch over an
// aligned 64-bit memory port, and decoded fields for the D pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        F_stall_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_Cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [63:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        f_valid_o,
    output logic        f_busy_o,
    output logic [2:0]  f_stat_o,
    output logic [63:0] f_pc_o,
    output logic [3:0]  f_icode_o,
    output logic [3:0]  f_ifun_o,
    output logic [3:0]  f_rA_o,
    output logic [3:0]  f_rB_o,
    output logic [63:0] f_valC_o,
    output logic [63:0] f_valP_o
);

    fetch_state_t r_state;
    logic [63:0]  r_pc;
    logic [191:0] r_buf;
    logic [1:0]   r_nwords;
    logic         r_drop;
    f_fields_t    r_f;

    logic         w_mispredict;
    logic         w_redirect;
    logic [63:0]  w_redir_pc;
    logic         w_req;
    logic         w_outstanding;
    logic [191:0] w_buf_next;
    logic [2:0]   w_words;
    logic [5:0]   w_have;
    logic         w_done;
    logic [63:0]  w_pred_pc;
    logic         w_stop;

    logic [2:0]   w_stat;
    logic [3:0]   w_icode;
    logic [3:0]   w_ifun;
    logic [3:0]   w_rA;
    logic [3:0]   w_rB;
    logic [63:0]  w_valC;
    logic [63:0]  w_valP;
    logic [3:0]   w_len;

    assign w_mispredict = (M_icode_i == IJXX) && !M_Cnd_i;
    assign w_redirect   = w_mispredict || (W_icode_i == IRET);
    assign w_redir_pc   = w_mispredict ? M_valA_i : W_valM_i;

    assign w_req        = (r_state == ST_ISSUE) && !r_drop && !rst_i;

    // A request is still in flight after this cycle unless its response lands now.
    always_comb begin
        w_outstanding = 1'b0;
        if (r_drop || (r_state == ST_WAIT)) begin
            w_outstanding = !imem_rvalid_i;
        end else if (r_state == ST_ISSUE) begin
            w_outstanding = w_req;
        end
    end

    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{r_nwords, 6'b000000} +: 64] = imem_rdata_i;
    end

    fetch_align u_align (
        .i_buf   (w_buf_next),
        .i_off   (r_pc[2:0]),
        .i_pc    (r_pc),
        .o_stat  (w_stat),
        .o_icode (w_icode),
        .o_ifun  (w_ifun),
        .o_rA    (w_rA),
        .o_rB    (w_rB),
        .o_valC  (w_valC),
        .o_valP  (w_valP),
        .o_len   (w_len)
    );

    // Bytes available from the PC offset once the arriving word is appended.
    assign w_words   = {1'b0, r_nwords} + 3'd1;
    assign w_have    = {w_words, 3'b000} - {3'b000, r_pc[2:0]};
    assign w_done    = (w_have >= {2'b00, w_len});

    assign w_pred_pc = ((r_f.icode == IJXX) || (r_f.icode == ICALL)) ? r_f.valC : r_f.valP;
    assign w_stop    = (r_f.stat == STAT_HLT) || (r_f.stat == STAT_ADR) || (r_f.stat == STAT_INS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_ISSUE;
            r_pc     <= RESET_PC;
            r_buf    <= '0;
            r_nwords <= '0;
            r_drop   <= 1'b0;
            r_f      <= F_BUBBLE;
        end else if (w_redirect) begin
            r_state  <= ST_ISSUE;
            r_pc     <= w_redir_pc;
            r_nwords <= '0;
            r_drop   <= w_outstanding;
            r_f      <= F_BUBBLE;
        end else begin
            if (r_drop && imem_rvalid_i) begin
                r_drop <= 1'b0;
            end
            case (r_state)
                ST_ISSUE: begin
                    if (!r_drop) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (imem_err_i) begin
                            r_state <= ST_READY;
                            r_f     <= '{stat: STAT_ADR, pc: r_pc, icode: INOP, ifun: 4'h0,
                                         rA: RNONE, rB: RNONE, valC: 64'h0, valP: r_pc};
                        end else begin
                            r_buf    <= w_buf_next;
                            r_nwords <= r_nwords + 2'd1;
                            if (w_done) begin
                                r_state <= ST_READY;
                                r_f     <= '{stat: w_stat, pc: r_pc, icode: w_icode, ifun: w_ifun,
                                             rA: w_rA, rB: w_rB, valC: w_valC, valP: w_valP};
                            end else begin
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
                end
                ST_READY: begin
                    if (!F_stall_i) begin
                        r_nwords <= '0;
                        if (w_stop) begin
                            r_state <= ST_HALTED;
                        end else begin
                            r_state <= ST_ISSUE;
                            r_pc    <= w_pred_pc;
                            r_f     <= F_BUBBLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_HALTED;
                end
            endcase
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = {r_pc[63:3], 3'b000} + {59'h0, r_nwords, 3'b000};

    assign f_valid_o   = (r_state == ST_READY) || (r_state == ST_HALTED);
    assign f_busy_o    = !f_valid_o;
    assign f_stat_o    = r_f.stat;
    assign f_pc_o      = r_f.pc;
    assign f_icode_o   = r_f.icode;
    assign f_ifun_o    = r_f.ifun;
    assign f_rA_o      = r_f.rA;
    assign f_rB_o      = r_f.rB;
    assign f_valC_o    = r_f.valC;
    assign f_valP_o    = r_f.valP;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: byte-addressed memory model with a
// configurable response delay and a scoreboard of expected decoded instructions.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        F_stall_i;
    logic [3:0]  M_icode_i;
    logic        M_Cnd_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [63:0] imem_rdata_i;
    logic        imem_err_i;
    logic        f_valid_o;
    logic        f_busy_o;
    logic [2:0]  f_stat_o;
    logic [63:0] f_pc_o;
    logic [3:0]  f_icode_o;
    logic [3:0]  f_ifun_o;
    logic [3:0]  f_rA_o;
    logic [3:0]  f_rB_o;
    logic [63:0] f_valC_o;
    logic [63:0] f_valP_o;

    always #5 clk_i = ~clk_i;

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .F_stall_i     (F_stall_i),
        .M_icode_i     (M_icode_i),
        .M_Cnd_i       (M_Cnd_i),
        .M_valA_i      (M_valA_i),
        .W_icode_i     (W_icode_i),
        .W_valM_i      (W_valM_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i),
        .f_valid_o     (f_valid_o),
        .f_busy_o      (f_busy_o),
        .f_stat_o      (f_stat_o),
        .f_pc_o        (f_pc_o),
        .f_icode_o     (f_icode_o),
        .f_ifun_o      (f_ifun_o),
        .f_rA_o        (f_rA_o),
        .f_rB_o        (f_rB_o),
        .f_valC_o      (f_valC_o),
        .f_valP_o      (f_valP_o)
    );

    localparam f_fields_t BUBBLE = '{stat: 3'd0, pc: 64'h0, icode: 4'h1, ifun: 4'h0,
                                     rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h0};

    logic [7:0]  mem [0:511];
    int          mem_extra = 0;
    int          cyc = 0;
    int          req_count = 0;
    logic [63:0] req_addrs[$];
    logic [63:0] rsp_addr;
    int          n_checks = 0;
    int          n_pass = 0;
    f_fields_t   sb[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory model: addresses at or above 0x100 answer with an error.
    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 64'h0;
        imem_err_i    = 1'b0;
        forever begin
            @(negedge clk_i);
            if (imem_req_o === 1'b1) begin
                rsp_addr = imem_addr_o;
                req_count++;
                req_addrs.push_back(rsp_addr);
                @(posedge clk_i); #1;
                repeat (mem_extra) begin @(posedge clk_i); #1; end
                imem_rvalid_i = 1'b1;
                imem_err_i    = (rsp_addr >= 64'h100);
                for (int k = 0; k < 8; k++)
                    imem_rdata_i[8*k +: 8] = imem_err_i ? 8'h00 : mem[{1'b0, rsp_addr[7:0]} + 9'(k)];
                @(posedge clk_i); #1;
                imem_rvalid_i = 1'b0;
                imem_err_i    = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic f_fields_t observed();
        return '{stat: f_stat_o, pc: f_pc_o, icode: f_icode_o, ifun: f_ifun_o,
                 rA: f_rA_o, rB: f_rB_o, valC: f_valC_o, valP: f_valP_o};
    endfunction

    task automatic load_bytes(input logic [8:0] addr, input int n, input logic [79:0] v);
        for (int i = 0; i < n; i++) mem[addr + 9'(i)] = v[8*i +: 8];
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_i);
            if (f_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic consume();
        F_stall_i = 1'b0;
        @(posedge clk_i); #1;
        F_stall_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic redirect_m(input logic [63:0] pc);
        M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = pc;
        @(posedge clk_i); #1;
        M_icode_i = INOP; M_Cnd_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic redirect_w(input logic [63:0] pc);
        W_icode_i = IRET; W_valM_i = pc;
        @(posedge clk_i); #1;
        W_icode_i = INOP;
        @(negedge clk_i);
    endtask

    int t0;

    task automatic test_reset();
        rst_i = 1'b1; F_stall_i = 1'b1;
        M_icode_i = INOP; M_Cnd_i = 1'b1; M_valA_i = 64'h0;
        W_icode_i = INOP; W_valM_i = 64'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if (imem_req_o !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req_o); else n_pass++;
        n_checks++;
        if (f_valid_o !== 1'b0 || f_busy_o !== 1'b1)
            $display("FAIL reset_valid_busy: got %b/%b want 0/1", f_valid_o, f_busy_o);
        else n_pass++;
        n_checks++;
        if (observed() !== BUBBLE) $display("FAIL reset_bubble: got %h want %h", observed(), BUBBLE); else n_pass++;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        t0 = cyc;
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0)
            $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o);
        else n_pass++;
    endtask

    task automatic test_nop();
        f_fields_t e;
        bit ok;
        sb.push_back('{stat: STAT_AOK, pc: 64'h0, icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h1});
        wait_valid(20, ok);
        n_checks++;
        if (!ok || (cyc - t0) != 2) $display("FAIL nop_latency: got %0d cycles want 2", cyc - t0); else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) $display("FAIL nop_pc0: got %h want %h", observed(), e); else n_pass++;
        consume();
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0)
            $display("FAIL nop_next_req: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o);
        else n_pass++;
        sb.push_back('{stat: STAT_AOK, pc: 64'h1, icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h2});
        wait_valid(20, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || observed() !== e) $display("FAIL nop_pc1: got %h want %h", observed(), e); else n_pass++;
    endtask

    task automatic test_irmovq_span();
        f_fields_t e;
        bit ok;
        int base;
        load_bytes(9'h7, 10, 80'h1122334455667788_F030);
        base = req_addrs.size();
        M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = 64'h7;
        @(posedge clk_i); #1;
        M_icode_i = INOP; M_Cnd_i = 1'b1;
        @(negedge clk_i);
        t0 = cyc;
        sb.push_back('{stat: STAT_AOK, pc: 64'h7, icode: 4'h3, ifun: 4'h0, rA: 4'hF, rB: 4'h0,
                       valC: 64'h1122334455667788, valP: 64'h11});
        wait_valid(40, ok);
        n_checks++;
        if (!ok || (cyc - t0) != 6) $display("FAIL irmovq_latency: got %0d cycles want 6", cyc - t0); else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (observed() !== e) $display("FAIL irmovq_fields: got %h want %h", observed(), e); else n_pass++;
        n_checks++;
        if (req_addrs.size() != base + 3 || req_addrs[base] !== 64'h0 ||
            req_addrs[base+1] !== 64'h8 || req_addrs[base+2] !== 64'h10)
            $display("FAIL irmovq_reqs: got %0d requests want 3 at 0,8,10", req_addrs.size() - base);
        else n_pass++;
    endtask

    task automatic test_stall();
        f_fields_t snap, e;
        int rc;
        bit ok;
        snap = observed();
        rc = req_count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (f_valid_o !== 1'b1 || observed() !== snap)
                $display("FAIL stall_hold_%0d: got %h want %h", i, observed(), snap);
            else n_pass++;
        end
        n_checks++;
        if (req_count != rc) $display("FAIL stall_no_req: got %0d want %0d", req_count, rc); else n_pass++;
        consume();
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h10)
            $display("FAIL stall_next_req: got req=%b addr=%h want 1/10", imem_req_o, imem_addr_o);
        else n_pass++;
        sb.push_back('{stat: STAT_AOK, pc: 64'h11, icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h12});
        wait_valid(20, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || observed() !== e) $display("FAIL stall_advance: got %h want %h", observed(), e); else n_pass++;
    endtask

    task automatic test_drop();
        f_fields_t e;
        bit ok;
        int base;
        load_bytes(9'h30, 9, 80'h0000000000000040_70);
        load_bytes(9'h9, 2, 80'h2360);
        redirect_m(64'h30);
        sb.push_back('{stat: STAT_AOK, pc: 64'h30, icode: 4'h7, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h40, valP: 64'h39});
        wait_valid(40, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || observed() !== e) $display("FAIL jxx_fields: got %h want %h", observed(), e); else n_pass++;
        mem_extra = 3;
        base = req_addrs.size();
        consume();
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h40)
            $display("FAIL jxx_target_req: got req=%b addr=%h want 1/40", imem_req_o, imem_addr_o);
        else n_pass++;
        sb.push_back('{stat: STAT_AOK, pc: 64'h9, icode: 4'h6, ifun: 4'h0, rA: 4'h2, rB: 4'h3, valC: 64'h0, valP: 64'hB});
        redirect_m(64'h9);
        wait_valid(60, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || observed() !== e) $display("FAIL drop_fields: got %h want %h", observed(), e); else n_pass++;
        n_checks++;
        if (req_addrs.size() != base + 2 || req_addrs[base+1] !== 64'h8)
            $display("FAIL drop_reqs: got %0d requests want 2 (40 then 8)", req_addrs.size() - base);
        else n_pass++;
        mem_extra = 0;
    endtask

    task automatic test_err_halt();
        f_fields_t e;
        bit ok;
        int rc;
        redirect_w(64'h200);
        wait_valid(20, ok);
        n_checks++;
        if (!ok || f_stat_o !== STAT_ADR || f_pc_o !== 64'h200)
            $display("FAIL err_adr: got stat=%0d pc=%h want %0d/200", f_stat_o, f_pc_o, STAT_ADR);
        else n_pass++;
        consume();
        rc = req_count;
        repeat (5) @(negedge clk_i);
        n_checks++;
        if (req_count != rc || f_stat_o !== STAT_ADR || f_pc_o !== 64'h200)
            $display("FAIL err_halted: got reqs=%0d stat=%0d want %0d/%0d", req_count - rc, f_stat_o, 0, STAT_ADR);
        else n_pass++;
        mem[9'h20] = 8'h00;
        redirect_w(64'h20);
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h20)
            $display("FAIL ret_req: got req=%b addr=%h want 1/20", imem_req_o, imem_addr_o);
        else n_pass++;
        sb.push_back('{stat: STAT_HLT, pc: 64'h20, icode: 4'h0, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h21});
        wait_valid(20, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || observed() !== e) $display("FAIL halt_fields: got %h want %h", observed(), e); else n_pass++;
    endtask

    task automatic test_ins_priority();
        f_fields_t e;
        bit ok;
        int rc;
        mem[9'h0] = 8'hC0;
        M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = 64'h0;
        W_icode_i = IRET; W_valM_i = 64'h20;
        @(posedge clk_i); #1;
        M_icode_i = INOP; M_Cnd_i = 1'b1; W_icode_i = INOP;
        @(negedge clk_i);
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0)
            $display("FAIL redirect_priority: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o);
        else n_pass++;
        sb.push_back('{stat: STAT_INS, pc: 64'h0, icode: 4'hC, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h1});
        wait_valid(20, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || observed() !== e) $display("FAIL ins_fields: got %h want %h", observed(), e); else n_pass++;
        consume();
        rc = req_count;
        repeat (5) @(negedge clk_i);
        n_checks++;
        if (req_count != rc || observed() !== e)
            $display("FAIL ins_halted: got reqs=%0d fields=%h want 0/%h", req_count - rc, observed(), e);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h10;
        test_reset();
        test_nop();
        test_irmovq_span();
        test_stall();
        test_drop();
        test_err_halt();
        test_ins_priority();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
